// File: rtl/multi_hit_encoder.sv
// multi_hit_encoder
//
// Clocked multi-hit priority encoder. A request vector is captured through a
// valid/ready handshake and every set bit is then emitted as an index, one
// per output transfer, in priority order. The final index of a vector carries
// out_last. An accepted all-zero vector produces a one-cycle `none` pulse
// instead of any output transfer.
//
// Parameters
//   N          request vector width (N >= 1)
//   HIGH_FIRST 1: highest-numbered set bit first, 0: lowest-numbered first
//   W          index width, clog2(N) (1 when N == 1), derived
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   req is valid this cycle
//   in_ready   block can accept a new vector (IDLE and not in reset)
//   req        request vector, bit i set = hit at index i
//   out_valid  idx/out_last hold a valid hit
//   out_ready  consumer accepts the current hit
//   idx        index of the current hit, 0 when out_valid is low
//   out_last   current hit is the last set bit of the captured vector
//   none       one-cycle pulse after an all-zero vector was accepted
//
// States
//   state | meaning
//   IDLE  | waiting for a vector, in_ready high
//   BUSY  | emitting the set bits of pending_q, out_valid high

module multi_hit_encoder #(
  parameter int unsigned N          = 8,
  parameter bit          HIGH_FIRST = 1'b1,
  localparam int unsigned W         = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] idx,
  output logic         out_last,
  output logic         none
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic           none_q, none_d;

  logic [W-1:0]   sel_idx;
  logic [N-1:0]   sel_mask;
  logic           single_bit;

  // Priority select over the registered pending vector only, so idx and
  // out_last never depend on live inputs and stay stable during a stall.
  // The winning bit is the last one visited by the scan.
  always_comb begin
    sel_idx  = '0;
    sel_mask = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < int'(N); i++) begin
        if (pending_q[i]) begin
          sel_idx     = W'(i);
          sel_mask    = '0;
          sel_mask[i] = 1'b1;
        end
      end
    end else begin
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (pending_q[i]) begin
          sel_idx     = W'(i);
          sel_mask    = '0;
          sel_mask[i] = 1'b1;
        end
      end
    end
  end

  // Exactly one bit set: clearing the lowest set bit leaves nothing.
  // pending_q is never zero while BUSY, so the zero case needs no guard here.
  assign single_bit = ((pending_q & (pending_q - N'(1))) == '0);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    none_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (req != '0) begin
            pending_d = req;
            state_d   = BUSY;
          end else begin
            none_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (out_ready) begin
          pending_d = pending_q & ~sel_mask;
          if (single_bit) begin
            pending_d = '0;
            state_d   = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      none_q    <= none_d;
    end
  end

  // Gating with rst keeps in_ready low for the whole reset, not only until
  // the first edge after it.
  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = (state_q == BUSY);
  assign idx       = out_valid ? sel_idx : '0;
  assign out_last  = out_valid & single_bit;
  assign none      = none_q;

endmodule
